// File: rtl/i_cache_pkg.sv
// Shared definitions for the instruction cache: pipeline encodings,
// cache geometry and the fill FSM state type.
package i_cache_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 8;

  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  // Instruction returned to fetch whenever the cache cannot supply one
  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  // CPU run state encodings
  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_EXEC = 1'b1;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_FILL = 1'b1
  } fsm_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/i_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read keyed by pc, one word write port, and a line
// completion port that writes the tag and sets the valid bit.
module i_cache_array
  import i_cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rd_pc,
  output logic                rd_hit,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                line_en,
  input  logic [TAG_W-1:0]    line_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [DATA_W-1:0]    data [NUM_LINES][LINE_WORDS];

  logic [INDEX_W-1:0]  rd_index;
  logic [OFFSET_W-1:0] rd_offset;
  logic [TAG_W-1:0]    rd_tag;

  assign rd_offset = rd_pc[OFFSET_W-1:0];
  assign rd_index  = rd_pc[OFFSET_W +: INDEX_W];
  assign rd_tag    = rd_pc[ADDR_W-1 -: TAG_W];

  // Lookup: a hit needs a valid line whose stored tag matches the pc tag
  always_comb begin
    rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
    rd_data = data[rd_index][rd_offset];
  end

  // Valid bits: cleared by reset or flush; flush beats a same-cycle line completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (line_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data[wr_index][wr_offset] <= wr_data;
    end
    if (line_en) begin
      tags[wr_index] <= line_tag;
    end
  end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache in front of the fetch stage.
// Hits return the instruction in the same cycle; misses stall fetch and
// refill a 4-word line over a req/ack handshake. Flush invalidates all lines.
module i_cache
  import i_cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] i_datain,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  fsm_t fsm_q, fsm_d;

  logic [ADDR_W-1:0]   base_q;
  logic [OFFSET_W-1:0] word_q;
  logic                discard_q;

  logic              raw_hit;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              exec;
  logic              start_fill;
  logic              word_ack;
  logic              last_word;
  logic              fill_end;
  logic              line_commit;

  // A flush cycle looks like a miss to fetch but never launches a fill
  assign hit         = raw_hit && !flush;
  assign exec        = (state == STATE_EXEC);
  assign start_fill  = (fsm_q == FSM_IDLE) && exec && !raw_hit && !flush;
  assign word_ack    = (fsm_q == FSM_FILL) && mem_ack;
  assign last_word   = (word_q == OFFSET_W'(LINE_WORDS - 1));
  assign fill_end    = word_ack && (last_word || discard_q || flush);
  assign line_commit = word_ack && last_word && !discard_q && !flush;

  i_cache_array u_array (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .rd_pc     (pc),
    .rd_hit    (raw_hit),
    .rd_data   (line_data),
    .wr_en     (word_ack),
    .wr_index  (base_q[OFFSET_W +: INDEX_W]),
    .wr_offset (word_q),
    .wr_data   (mem_rdata),
    .line_en   (line_commit),
    .line_tag  (base_q[ADDR_W-1 -: TAG_W])
  );

  // FSM state register; reset aborts any fill in progress immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next state plus fetch-facing and memory-facing outputs
  always_comb begin
    fsm_d    = fsm_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    i_datain = NOP;
    stall    = exec && ((fsm_q != FSM_IDLE) || !hit);
    case (fsm_q)
      FSM_IDLE: begin
        if (hit) begin
          i_datain = line_data;
        end
        if (start_fill) begin
          fsm_d = FSM_FILL;
        end
      end
      FSM_FILL: begin
        mem_req  = 1'b1;
        mem_addr = base_q | ADDR_W'(word_q);
        if (fill_end) begin
          fsm_d = FSM_IDLE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  // Fill bookkeeping (line base, word counter, discard) and saturating counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      word_q    <= '0;
      discard_q <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (start_fill) begin
        base_q   <= {pc[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        word_q   <= '0;
        miss_cnt <= sat_inc(miss_cnt);
      end else if (word_ack) begin
        word_q <= word_q + OFFSET_W'(1);
      end
      if (fill_end) begin
        discard_q <= 1'b0;
      end else if ((fsm_q == FSM_FILL) && flush) begin
        discard_q <= 1'b1;
      end
      if ((fsm_q == FSM_IDLE) && exec && hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// Directed testbench for i_cache: cold and conflict misses, hits, flush
// during a fill, reset mid-fill and the idle run state.
module tb_i_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        state;
  logic [7:0]  pc;
  logic        flush;
  logic [15:0] i_datain;
  logic        stall;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int wait_cnt;
  logic [7:0] addr_log [$];

  i_cache dut (
    .clock     (clock),
    .reset     (reset),
    .state     (state),
    .pc        (pc),
    .flush     (flush),
    .i_datain  (i_datain),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Instruction memory image: word at a is {a+11h, a+01h}, e.g. 00 -> 1101
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a + 8'h11, a + 8'h01};
  endfunction

  // Memory responder: acks each request on the second sample after it appears
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    wait_cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset || mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          addr_log.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Safety net in case the stimulus itself stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] p, input logic fl);
    state = st;
    pc    = p;
    flush = fl;
    #1;
  endtask

  task automatic waitForHit(input string tag);
    int n = 0;
    while (stall && n < 80) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic waitForLog(input int count, input string tag);
    int n = 0;
    while (addr_log.size() < count && n < 80) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_log_size"}, addr_log.size(), count);
  endtask

  initial begin
    logic [15:0] hit_exp [4];
    int n;
    hit_exp[0] = 16'h1101;
    hit_exp[1] = 16'h1202;
    hit_exp[2] = 16'h1303;
    hit_exp[3] = 16'h1404;

    // Reset with a fetch pending
    reset = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0);
    reset = 1'b0;
    #2;
    checkOutput("rst_stall", {31'b0, stall}, 32'd1);
    checkOutput("rst_data", i_datain, 32'h0000);
    checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
    checkOutput("rst_hit_cnt", hit_cnt, 32'd0);

    // Cold miss on pc 00
    waitForHit("cold");
    checkOutput("cold_log_size", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cold_addr", addr_log[i], i);
    end
    checkOutput("cold_data", i_datain, 32'h1101);
    checkOutput("cold_miss_cnt", miss_cnt, 32'd1);

    // Hits on the rest of the line
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("hit_data", i_datain, hit_exp[i]);
      checkOutput("hit_stall", {31'b0, stall}, 32'd0);
    end
    @(negedge clock);
    checkOutput("hit_cnt", hit_cnt, 32'd4);
    checkOutput("hit_no_req", addr_log.size(), 32'd4);

    // Conflict miss: pc 20 evicts line 0, then pc 00 misses again
    addr_log.delete();
    applyStimulus(1'b1, 8'h20, 1'b0);
    checkOutput("conf_stall", {31'b0, stall}, 32'd1);
    waitForHit("conf20");
    checkOutput("conf_first", addr_log[0], 32'h20);
    checkOutput("conf_last", addr_log[3], 32'h23);
    checkOutput("conf_data", i_datain, 32'h3121);
    addr_log.delete();
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("conf_back_stall", {31'b0, stall}, 32'd1);
    waitForHit("conf00");
    checkOutput("conf_back_addr", addr_log[0], 32'h00);
    checkOutput("conf_back_data", i_datain, 32'h1101);
    checkOutput("conf_miss_cnt", miss_cnt, 32'd3);

    // Flush while waiting for the second word of a fill
    addr_log.delete();
    applyStimulus(1'b1, 8'h40, 1'b0);
    waitForLog(1, "flush_w0");
    @(negedge clock);
    applyStimulus(1'b1, 8'h40, 1'b1);
    checkOutput("flush_stall", {31'b0, stall}, 32'd1);
    checkOutput("flush_data", i_datain, 32'h0000);
    @(negedge clock);
    applyStimulus(1'b1, 8'h40, 1'b0);
    waitForLog(3, "flush_refetch");
    checkOutput("flush_w1_addr", addr_log[1], 32'h41);
    checkOutput("flush_restart_addr", addr_log[2], 32'h40);
    waitForHit("flush_fill");
    checkOutput("flush_data_after", i_datain, 32'h5141);
    checkOutput("flush_miss_cnt", miss_cnt, 32'd5);

    // Cache pc 00, then reset in the middle of a fill for pc 04
    applyStimulus(1'b1, 8'h00, 1'b0);
    waitForHit("pre_rst");
    checkOutput("pre_rst_data", i_datain, 32'h1101);
    applyStimulus(1'b1, 8'h04, 1'b0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mid_req_seen", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("mid_rst_addr", mem_addr, 32'h00);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(1'b1, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_stall", {31'b0, stall}, 32'd1);
    checkOutput("post_rst_data", i_datain, 32'h0000);
    checkOutput("post_rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clock);
    checkOutput("post_rst_req", {31'b0, mem_req}, 32'd1);
    checkOutput("post_rst_addr", mem_addr, 32'h00);
    waitForHit("post_rst");
    checkOutput("post_rst_fill_data", i_datain, 32'h1101);

    // Idle run state: a miss neither stalls nor starts a fill
    applyStimulus(1'b0, 8'h60, 1'b0);
    checkOutput("idle_stall", {31'b0, stall}, 32'd0);
    checkOutput("idle_data", i_datain, 32'h0000);
    @(negedge clock);
    @(negedge clock);
    checkOutput("idle_req", {31'b0, mem_req}, 32'd0);
    checkOutput("idle_miss_cnt", miss_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
